instr_fetch_unit: RTL and testbench

- Fetch stage that sits around PC_Register.
- Upstream role: drives new_PC into PC_Register every cycle.
- Downstream role: consumes current_PC, reads instruction memory over a req/ack handshake, and presents one instruction at a time to decode with valid/stall flow control.
- Handles taken branches and jumps by redirecting the PC and flushing fetched or in-flight instructions.
- Includes a one-entry skid buffer so a late decode stall never loses an instruction.

---
 rtl/instr_fetch_unit.sv | 176 +++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Fetch stage wrapped around an external PC register.
// Issues one instruction-memory read at a time over req/ack, hands words to
// decode with valid/stall, and redirects on taken branches. A one-entry skid
// buffer catches a word that returns while decode is stalled on the output.
module instr_fetch_unit #(
   parameter int                ADDR_W   = 16,
   parameter int                INSTR_W  = 16,
   parameter int                PC_INC   = 2,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [ADDR_W-1:0]  current_PC,
   output logic [ADDR_W-1:0]  new_PC,
   input  logic               branch_taken,
   input  logic [ADDR_W-1:0]  branch_target,
   input  logic               stall,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic [INSTR_W-1:0] instr_out,
   output logic [ADDR_W-1:0]  instr_pc,
   output logic               instr_valid
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(PC_INC);

   state_t               state_q;
   state_t               state_d;
   logic                 drop_q;
   logic                 skid_valid;
   logic [INSTR_W-1:0]   skid_instr;
   logic [ADDR_W-1:0]    skid_pc;

   logic                 consume;
   logic                 slot_free;
   logic                 ack_accept;
   logic                 ack_discard;

   assign consume     = instr_valid && !stall;
   assign slot_free   = !instr_valid || consume;
   assign ack_accept  = (state_q == REQ) && imem_ack && !drop_q && !branch_taken;
   assign ack_discard = (state_q == REQ) && imem_ack && (drop_q || branch_taken);

   // Next PC for the external register: redirect first, then advance past an
   // accepted word, otherwise hold whatever the register already has.
   always_comb begin
      new_PC = current_PC;
      if (branch_taken) begin
         new_PC = branch_target;
      end else if (ack_accept) begin
         new_PC = imem_addr + PC_STEP;
      end
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: a branch parks IDLE/DRAIN in IDLE so the new PC has a
   // cycle to land in the PC register before it is sampled as an address.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = branch_taken ? IDLE : REQ;
         REQ:     state_d = (ack_accept && !slot_free) ? DRAIN : REQ;
         DRAIN: begin
            if (branch_taken) begin
               state_d = IDLE;
            end else if (!stall) begin
               state_d = REQ;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output logic: a request is outstanding exactly while in REQ.
   always_comb begin
      imem_req = (state_q == REQ);
   end

   // Request address and drop flag: the address only moves when no request is
   // pending, and a branch during a pending request marks its data for discard.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         imem_addr <= RESET_PC;
         drop_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (!branch_taken) begin
                  imem_addr <= current_PC;
               end
            end
            REQ: begin
               if ((ack_accept && slot_free) || ack_discard) begin
                  imem_addr <= new_PC;
               end
               if (imem_ack) begin
                  drop_q <= 1'b0;
               end else if (branch_taken) begin
                  drop_q <= 1'b1;
               end
            end
            DRAIN: begin
               if (!branch_taken && !stall) begin
                  imem_addr <= current_PC;
               end
            end
            default: ;
         endcase
      end
   end

   // Output slot and skid buffer: a branch flushes both; otherwise accepted
   // words go to the output when it frees up, or park in the skid if not.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         instr_out   <= '0;
         instr_pc    <= '0;
         instr_valid <= 1'b0;
         skid_valid  <= 1'b0;
         skid_instr  <= '0;
         skid_pc     <= '0;
      end else if (branch_taken) begin
         instr_valid <= 1'b0;
         skid_valid  <= 1'b0;
      end else begin
         case (state_q)
            REQ: begin
               if (ack_accept && slot_free) begin
                  instr_out   <= imem_rdata;
                  instr_pc    <= imem_addr;
                  instr_valid <= 1'b1;
               end else begin
                  if (consume) begin
                     instr_valid <= 1'b0;
                  end
                  if (ack_accept) begin
                     skid_valid <= 1'b1;
                     skid_instr <= imem_rdata;
                     skid_pc    <= imem_addr;
                  end
               end
            end
            DRAIN: begin
               if (!stall && skid_valid) begin
                  instr_out   <= skid_instr;
                  instr_pc    <= skid_pc;
                  instr_valid <= 1'b1;
                  skid_valid  <= 1'b0;
               end
            end
            default: begin
               if (consume) begin
                  instr_valid <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: models the PC register and a memory with a
// programmable number of wait cycles, and scores every delivered instruction
// against a queue of expected {pc, word} pairs.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] current_PC;
   logic [15:0] new_PC;
   logic        branch_taken = 1'b0;
   logic [15:0] branch_target = 16'h0000;
   logic        stall = 1'b0;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ack;
   logic [15:0] imem_rdata;
   logic [15:0] instr_out;
   logic [15:0] instr_pc;
   logic        instr_valid;

   logic [15:0] pc_init = 16'h0000;
   int          mem_wait = 0;
   int          wait_cnt;
   logic        late_ack = 1'b0;
   logic        mon_en = 1'b0;
   logic [31:0] sb[$];

   int          total = 0;
   int          bad = 0;

   instr_fetch_unit #(
      .ADDR_W   (16),
      .INSTR_W  (16),
      .PC_INC   (2),
      .RESET_PC (16'h0000)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .current_PC    (current_PC),
      .new_PC        (new_PC),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .stall         (stall),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ack      (imem_ack),
      .imem_rdata    (imem_rdata),
      .instr_out     (instr_out),
      .instr_pc      (instr_pc),
      .instr_valid   (instr_valid)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      return a ^ 16'hA5A3;
   endfunction

   assign imem_rdata = mem_word(imem_addr);
   assign imem_ack   = (imem_req && (wait_cnt >= mem_wait)) || late_ack;

   // PC register model: loads new_PC every edge, resets to pc_init.
   always @(posedge clk or posedge reset) begin
      if (reset) current_PC <= pc_init;
      else       current_PC <= new_PC;
   end

   // Memory wait counter: counts cycles a request has been pending.
   always @(posedge clk or posedge reset) begin
      if (reset)                      wait_cnt <= 0;
      else if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
      else                            wait_cnt <= 0;
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push_seq(input logic [15:0] start, input int n);
      logic [15:0] pc;
      pc = start;
      for (int i = 0; i < n; i++) begin
         sb.push_back({pc, mem_word(pc)});
         pc = pc + 16'd2;
      end
   endtask

   task automatic do_reset(input logic [15:0] pc_val);
      @(posedge clk);
      #1;
      mon_en        = 1'b0;
      sb.delete();
      stall         = 1'b0;
      branch_taken  = 1'b0;
      late_ack      = 1'b0;
      mem_wait      = 0;
      pc_init       = pc_val;
      reset         = 1'b1;
      cyc();
      cyc();
      reset         = 1'b0;
   endtask

   // Scoreboard: every consumed instruction must match the head of the queue.
   task automatic monitor_loop();
      logic [31:0] exp_v;
      forever begin
         @(negedge clk);
         if (mon_en && !reset && instr_valid && !stall) begin
            total++;
            if (sb.size() == 0) begin
               bad++;
               $display("[TB] FAIL deliver_unexpected: got pc=%h instr=%h, required no delivery", instr_pc, instr_out);
            end else begin
               exp_v = sb.pop_front();
               if ({instr_pc, instr_out} !== exp_v) begin
                  bad++;
                  $display("[TB] FAIL deliver: got pc=%h instr=%h, required pc=%h instr=%h",
                           instr_pc, instr_out, exp_v[31:16], exp_v[15:0]);
               end
            end
         end
      end
   endtask

   task automatic test_reset();
      #1 reset = 1'b1;
      @(negedge clk);
      total++; if (imem_req !== 1'b0) begin bad++; $display("[TB] FAIL rst_req: got %b required 0", imem_req); end
      total++; if (imem_addr !== 16'h0000) begin bad++; $display("[TB] FAIL rst_addr: got %h required 0000", imem_addr); end
      total++; if (instr_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_valid: got %b required 0", instr_valid); end
      total++; if (instr_out !== 16'h0000) begin bad++; $display("[TB] FAIL rst_instr: got %h required 0000", instr_out); end
      total++; if (instr_pc !== 16'h0000) begin bad++; $display("[TB] FAIL rst_pc: got %h required 0000", instr_pc); end
      total++; if (new_PC !== 16'h0000) begin bad++; $display("[TB] FAIL rst_newpc: got %h required 0000", new_PC); end
   endtask

   task automatic test_sequential();
      int n;
      do_reset(16'h0000);
      push_seq(16'h0000, 8);
      mon_en = 1'b1;
      cyc();
      total++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin bad++; $display("[TB] FAIL seq_first_req: got req=%b addr=%h required req=1 addr=0000", imem_req, imem_addr); end
      cyc();
      for (int k = 3; k <= 7; k++) begin
         cyc();
         total++; if (instr_valid !== 1'b1) begin bad++; $display("[TB] FAIL seq_valid_edge%0d: got %b required 1", k, instr_valid); end
      end
      n = 0;
      while (sb.size() != 0 && n < 60) begin @(negedge clk); #1; n++; end
      total++; if (sb.size() != 0) begin bad++; $display("[TB] FAIL seq_drain: got %0d undelivered required 0", sb.size()); end
      mon_en = 1'b0;
   endtask

   task automatic test_latency();
      int n;
      do_reset(16'h0000);
      mem_wait = 2;
      push_seq(16'h0000, 3);
      mon_en = 1'b1;
      n = 0;
      while (!(imem_req && imem_addr == 16'h0002) && n < 30) begin cyc(); n++; end
      total++; if (imem_addr !== 16'h0002) begin bad++; $display("[TB] FAIL lat_reach: got addr=%h required 0002", imem_addr); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total++; if (imem_addr !== 16'h0002) begin bad++; $display("[TB] FAIL lat_hold%0d: got addr=%h required 0002", i, imem_addr); end
         total++; if (new_PC !== ((i == 2) ? 16'h0004 : 16'h0002)) begin bad++; $display("[TB] FAIL lat_newpc%0d: got %h required %h", i, new_PC, (i == 2) ? 16'h0004 : 16'h0002); end
         cyc();
      end
      n = 0;
      while (sb.size() != 0 && n < 60) begin @(negedge clk); #1; n++; end
      total++; if (sb.size() != 0) begin bad++; $display("[TB] FAIL lat_drain: got %0d undelivered required 0", sb.size()); end
      mon_en = 1'b0;
   endtask

   task automatic test_skid();
      int n;
      do_reset(16'h0000);
      push_seq(16'h0000, 6);
      mon_en = 1'b1;
      n = 0;
      while (!(instr_valid && instr_pc == 16'h0004) && n < 30) begin cyc(); n++; end
      total++; if (instr_pc !== 16'h0004) begin bad++; $display("[TB] FAIL skid_reach: got pc=%h required 0004", instr_pc); end
      stall = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cyc();
         total++; if (imem_req !== 1'b0 || instr_pc !== 16'h0004 || instr_valid !== 1'b1) begin bad++; $display("[TB] FAIL skid_hold%0d: got req=%b pc=%h valid=%b required req=0 pc=0004 valid=1", i, imem_req, instr_pc, instr_valid); end
      end
      stall = 1'b0;
      cyc();
      total++; if (instr_out !== 16'hA5A5 || instr_pc !== 16'h0006) begin bad++; $display("[TB] FAIL skid_out: got instr=%h pc=%h required instr=a5a5 pc=0006", instr_out, instr_pc); end
      total++; if (imem_req !== 1'b1 || imem_addr !== 16'h0008) begin bad++; $display("[TB] FAIL skid_resume: got req=%b addr=%h required req=1 addr=0008", imem_req, imem_addr); end
      n = 0;
      while (sb.size() != 0 && n < 60) begin @(negedge clk); #1; n++; end
      total++; if (sb.size() != 0) begin bad++; $display("[TB] FAIL skid_drain: got %0d undelivered required 0", sb.size()); end
      mon_en = 1'b0;
   endtask

   task automatic test_branch_outstanding();
      int n;
      int hold;
      do_reset(16'h0010);
      mem_wait = 3;
      push_seq(16'h0100, 2);
      mon_en = 1'b1;
      cyc();
      total++; if (imem_req !== 1'b1 || imem_addr !== 16'h0010) begin bad++; $display("[TB] FAIL br_req: got req=%b addr=%h required req=1 addr=0010", imem_req, imem_addr); end
      branch_taken  = 1'b1;
      branch_target = 16'h0100;
      @(negedge clk);
      total++; if (new_PC !== 16'h0100) begin bad++; $display("[TB] FAIL br_newpc: got %h required 0100", new_PC); end
      cyc();
      branch_taken = 1'b0;
      hold = 0;
      n = 0;
      while (!instr_valid && n < 40) begin
         if (imem_req && imem_addr == 16'h0010) hold++;
         cyc();
         n++;
      end
      total++; if (hold != 3) begin bad++; $display("[TB] FAIL br_pending_cycles: got %0d required 3", hold); end
      total++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0100) begin bad++; $display("[TB] FAIL br_first: got valid=%b pc=%h required valid=1 pc=0100", instr_valid, instr_pc); end
      n = 0;
      while (sb.size() != 0 && n < 60) begin @(negedge clk); #1; n++; end
      total++; if (sb.size() != 0) begin bad++; $display("[TB] FAIL br_drain: got %0d undelivered required 0", sb.size()); end
      mon_en = 1'b0;
   endtask

   task automatic test_branch_with_ack();
      int n;
      do_reset(16'h0020);
      push_seq(16'h0200, 3);
      mon_en = 1'b1;
      cyc();
      branch_taken  = 1'b1;
      branch_target = 16'h0200;
      @(negedge clk);
      total++; if (imem_ack !== 1'b1 || new_PC !== 16'h0200) begin bad++; $display("[TB] FAIL brack_newpc: got ack=%b new_PC=%h required ack=1 new_PC=0200", imem_ack, new_PC); end
      cyc();
      branch_taken = 1'b0;
      total++; if (imem_addr !== 16'h0200 || instr_valid !== 1'b0) begin bad++; $display("[TB] FAIL brack_redirect: got addr=%h valid=%b required addr=0200 valid=0", imem_addr, instr_valid); end
      n = 0;
      while (sb.size() != 0 && n < 60) begin @(negedge clk); #1; n++; end
      total++; if (sb.size() != 0) begin bad++; $display("[TB] FAIL brack_drain: got %0d undelivered required 0", sb.size()); end
      mon_en = 1'b0;
   endtask

   task automatic test_wrap();
      int n;
      do_reset(16'hFFFE);
      push_seq(16'hFFFE, 3);
      mon_en = 1'b1;
      cyc();
      @(negedge clk);
      total++; if (new_PC !== 16'h0000) begin bad++; $display("[TB] FAIL wrap_newpc: got %h required 0000", new_PC); end
      n = 0;
      while (sb.size() != 0 && n < 60) begin @(negedge clk); #1; n++; end
      total++; if (sb.size() != 0) begin bad++; $display("[TB] FAIL wrap_drain: got %0d undelivered required 0", sb.size()); end
      mon_en = 1'b0;
   endtask

   task automatic test_branch_idle();
      int n;
      do_reset(16'h0000);
      branch_taken  = 1'b1;
      branch_target = 16'h0300;
      push_seq(16'h0300, 2);
      mon_en = 1'b1;
      cyc();
      branch_taken = 1'b0;
      total++; if (imem_req !== 1'b0) begin bad++; $display("[TB] FAIL bridle_wait: got req=%b required 0", imem_req); end
      cyc();
      total++; if (imem_req !== 1'b1 || imem_addr !== 16'h0300) begin bad++; $display("[TB] FAIL bridle_addr: got req=%b addr=%h required req=1 addr=0300", imem_req, imem_addr); end
      n = 0;
      while (sb.size() != 0 && n < 60) begin @(negedge clk); #1; n++; end
      total++; if (sb.size() != 0) begin bad++; $display("[TB] FAIL bridle_drain: got %0d undelivered required 0", sb.size()); end
      mon_en = 1'b0;
   endtask

   task automatic test_reset_mid_request();
      int n;
      do_reset(16'h0040);
      push_seq(16'h0040, 1);
      mon_en = 1'b1;
      cyc();
      cyc();
      mem_wait = 5;
      n = 0;
      while (sb.size() != 0 && n < 10) begin @(negedge clk); #1; n++; end
      total++; if (sb.size() != 0) begin bad++; $display("[TB] FAIL rmid_first: got %0d undelivered required 0", sb.size()); end
      mon_en = 1'b0;
      cyc();
      total++; if (imem_req !== 1'b1 || imem_addr !== 16'h0042 || instr_out !== mem_word(16'h0040)) begin bad++; $display("[TB] FAIL rmid_pending: got req=%b addr=%h instr=%h required req=1 addr=0042 instr=%h", imem_req, imem_addr, instr_out, mem_word(16'h0040)); end
      reset = 1'b1;
      #1;
      total++; if (imem_req !== 1'b0 || imem_addr !== 16'h0000) begin bad++; $display("[TB] FAIL rmid_req: got req=%b addr=%h required req=0 addr=0000", imem_req, imem_addr); end
      total++; if (instr_valid !== 1'b0 || instr_out !== 16'h0000 || instr_pc !== 16'h0000) begin bad++; $display("[TB] FAIL rmid_out: got valid=%b instr=%h pc=%h required 0/0000/0000", instr_valid, instr_out, instr_pc); end
      cyc();
      reset    = 1'b0;
      late_ack = 1'b1;
      @(negedge clk);
      total++; if (new_PC !== 16'h0040) begin bad++; $display("[TB] FAIL rmid_lateack_pc: got %h required 0040", new_PC); end
      cyc();
      late_ack = 1'b0;
      total++; if (imem_req !== 1'b1 || imem_addr !== 16'h0040 || instr_valid !== 1'b0) begin bad++; $display("[TB] FAIL rmid_restart: got req=%b addr=%h valid=%b required req=1 addr=0040 valid=0", imem_req, imem_addr, instr_valid); end
      mem_wait = 0;
      push_seq(16'h0040, 3);
      mon_en = 1'b1;
      n = 0;
      while (sb.size() != 0 && n < 60) begin @(negedge clk); #1; n++; end
      total++; if (sb.size() != 0) begin bad++; $display("[TB] FAIL rmid_drain: got %0d undelivered required 0", sb.size()); end
      mon_en = 1'b0;
   endtask

   initial begin
      $display("[TB] starting instr_fetch_unit bench");
      fork
         monitor_loop();
      join_none
      test_reset();
      test_sequential();
      test_latency();
      test_skid();
      test_branch_outstanding();
      test_branch_with_ack();
      test_wrap();
      test_branch_idle();
      test_reset_mid_request();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
